// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle sequencer for the HI/LO multiply/divide unit.
// Latches operands at launch, counts a fixed latency, then commits HI/LO
// and pulses done. Raises stall while a decode-stage MD instruction must wait.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d, dz_q, dz_d;

  logic        launch_op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, quot_s, rem_s, quot_u, rem_u;

  assign launch_op = (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  // Datapath on the latched operands; a zero divisor is replaced by 1 so the
  // divider never produces X (its result is discarded in that case anyway).
  always_comb begin
    div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    quot_s = $signed(a_q) / $signed(div_b);
    rem_s  = $signed(a_q) % $signed(div_b);
    quot_u = a_q / div_b;
    rem_u  = a_q % div_b;
  end

  // Next-state logic: launch / MTHI / MTLO in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (launch_op) begin
            a_d     = a;
            b_d     = b;
            op_d    = md_op;
            cnt_d   = (md_op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d = RUN;
          end else if (md_op == OP_MTHI) begin
            hi_d = a;
          end else if (md_op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            case (op_q)
              OP_MULT:  {hi_d, lo_d} = prod_s;
              OP_MULTU: {hi_d, lo_d} = prod_u;
              OP_DIV:   if (b_q == 32'd0) dz_d = 1'b1; else begin lo_d = quot_s; hi_d = rem_s; end
              OP_DIVU:  if (b_q == 32'd0) dz_d = 1'b1; else begin lo_d = quot_u; hi_d = rem_u; end
              default:  ;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign stall    = md_use_d & (busy | (start & launch_op));
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: inputs driven and outputs sampled on negedge.
module tb_md_scheduler;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0, md_use_d = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;
  int n_chk = 0, n_pass = 0;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .flush(flush), .md_use_d(md_use_d), .busy(busy), .stall(stall),
    .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive a start for one cycle; returns at the negedge after the launch edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  // Expect n busy cycles, then a done cycle with the given HI/LO, then done low.
  task automatic run_check(input string tag, input int n, input logic [31:0] ehi,
                           input logic [31:0] elo, input logic edz);
    for (int i = 0; i < n; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " nodone"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " dz"}, {31'd0, div_zero}, {31'd0, edz});
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #3;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // 1: signed MULT -2 * 3
    launch(3'd1, 32'hFFFFFFFE, 32'd3);
    run_check("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);

    // 2: MULTU, operands change after launch and a start arrives mid-run
    launch(3'd2, 32'hFFFFFFFF, 32'd2);
    a = 32'd9; b = 32'd0;
    @(negedge clk); start = 1'b1; md_op = 3'd4;
    @(negedge clk); start = 1'b0; md_op = 3'd0;
    run_check("multu", 3, 32'h00000001, 32'hFFFFFFFE, 1'b0);

    // 3: signed DIV -7 / 2, then DIVU by zero
    launch(3'd3, 32'hFFFFFFF9, 32'd2);
    run_check("div", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    launch(3'd4, 32'd7, 32'd0);
    run_check("divu0", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);

    // 4: stall across a MULT with an MD instruction waiting in decode
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; a = 32'd100; b = 32'd200; md_use_d = 1'b1;
    #1 chk("stall launch", {31'd0, stall}, 32'd1);
    @(negedge clk); start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      chk("stall busy", {31'd0, stall}, 32'd1);
      @(negedge clk);
    end
    chk("stall done", {31'd0, done}, 32'd1);
    chk("stall off", {31'd0, stall}, 32'd0);
    chk("mult2 lo", lo, 32'h00004E20);
    md_use_d = 1'b0;
    // MTHI in IDLE
    start = 1'b1; md_op = 3'd5; a = 32'h12345678;
    @(negedge clk); start = 1'b0; md_op = 3'd0;
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi lo", lo, 32'h00004E20);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi done", {31'd0, done}, 32'd0);

    // 5: DIV flushed at busy cycle 3
    launch(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush hi", hi, 32'h12345678);
    chk("flush lo", lo, 32'h00004E20);
    chk("flush dz", {31'd0, div_zero}, 32'd1);
    // flush also suppresses MTLO in IDLE
    start = 1'b1; md_op = 3'd6; a = 32'hDEADBEEF;
    @(negedge clk); start = 1'b0; md_op = 3'd0; flush = 1'b0;
    chk("flush mtlo", lo, 32'h00004E20);
    @(negedge clk);
    chk("flush late done", {31'd0, done}, 32'd0);

    // 6: async reset mid-run, then scenario 1 again
    launch(3'd1, 32'd5, 32'd6);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst hi", hi, 32'd0);
    chk("arst lo", lo, 32'd0);
    chk("arst dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); reset = 1'b1;
    launch(3'd1, 32'hFFFFFFFE, 32'd3);
    run_check("mult_again", 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource used by the execute stage.
- Accepts one MD operation per start pulse and runs it for a fixed parameterised latency.
- Owns the HI/LO registers and the done pulse.
- Raises a stall request toward decode while a later MD-using instruction must wait.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation in md_op this cycle
md_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
a  input  32  operand rs (forwarded value)
b  input  32  operand rt (forwarded value)
flush  input  1  abort in-flight operation (exception/pipeline flush)
md_use_d  input  1  instruction in decode is MD-class (mult/div/mthi/mtlo/mfhi/mflo)
busy  output  1  operation in progress
stall  output  1  freeze fetch/decode, bubble execute
done  output  1  one-cycle pulse: HI/LO just updated by mult/div
div_zero  output  1  sticky; set by DIV/DIVU with b==0, cleared by reset only
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0, async): state IDLE, counter 0, busy=0, done=0, div_zero=0, hi=0, lo=0, latched operands/op cleared.
- States: IDLE, RUN.
- IDLE, start=1, md_op in 1..4, flush=0:
  - latch a, b, op
  - load counter with MULT_CYCLES or DIV_CYCLES
  - next state RUN
- IDLE, start=1, md_op==5: hi<=a at that edge; no busy, no done.
- IDLE, start=1, md_op==6: lo<=a at that edge; no busy, no done.
- start with md_op 0 or 7: no effect.
- RUN: counter decrements each edge. At the edge where counter==1:
  - MULT: {hi,lo} <= signed a*b (64-bit)
  - MULTU: {hi,lo} <= unsigned a*b (64-bit)
  - DIV: lo <= signed quotient, hi <= signed remainder (remainder takes sign of dividend)
  - DIVU: lo <= unsigned quotient, hi <= unsigned remainder
  - divide with b==0: hi/lo unchanged, div_zero<=1
  - state<=IDLE; done=1 for the following cycle only.
- Latency: start sampled at edge k -> busy=1 after edges k..k+N-1 (N cycles) -> hi/lo updated at edge k+N -> done=1 and busy=0 in the cycle after edge k+N.
- busy = (state==RUN), registered.
- stall = md_use_d & (busy | (start & md_op in 1..4)); combinational. Covers the back-to-back hazard where the instruction in decode follows a launching mult/div.
- start asserted while busy: ignored (a protocol error; the stall prevents it). Operands and hi/lo are unaffected.
- flush=1 in RUN: abort at next edge; state IDLE, no hi/lo write, no done, div_zero unchanged.
- flush=1 with start in IDLE: flush wins; nothing launched; MTHI/MTLO suppressed.
- A completion edge coincides with a new start: start is not accepted because busy=1 that cycle. A start in the next cycle (IDLE) is accepted.
- Operands are latched at launch. Later changes on a/b do not affect the result.

Test Plan:
1. Reset released; start, MULT, a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, one-cycle done.
2. MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
3. DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 -> hi/lo unchanged, div_zero=1, done pulses.
4. MULT launched, md_use_d=1 in the same and next cycles -> stall=1 from the launch cycle through the last busy cycle, stall=0 the cycle done=1. MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0.
5. DIV launched, flush=1 at busy cycle 3 -> busy=0 next cycle, hi/lo keep prior values, no done pulse.
6. reset driven low mid-RUN, asynchronously between edges -> busy, done, hi, lo, div_zero all 0 immediately. Next start after release behaves as in scenario 1.
